// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared processor constants for the loader FSM, frame format and control-unit states
package prog_loader_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_HI    = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERROR = 3'd7;
  localparam logic [7:0] COUNT_FULL = 8'h00;
  localparam logic [1:0] CU_RESET  = 2'd0;
  localparam logic [1:0] CU_FETCH  = 2'd1;
  localparam logic [1:0] CU_DECODE = 2'd2;
  localparam logic [1:0] CU_EXEC   = 2'd3;
endpackage

// File: rtl/prog_loader.sv
// prog_loader: loads a checksummed byte-stream frame into instruction memory while holding the cpu
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int INST_W = 10,
  parameter int BYTE_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_address,
  output logic [INST_W-1:0] mem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [2:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] last;
  logic [BYTE_W-1:0] chk;
  logic [BYTE_W-1:0] lo;
  logic              accept;
  logic              too_big;
  // status outputs are pure state decodes so no input reaches an output combinationally
  always_comb begin
    in_ready = (state == S_COUNT) || (state == S_LO) || (state == S_HI) || (state == S_CHECK);
    accept   = in_valid && in_ready;
    mem_wren = state == S_WRITE;
    done     = state == S_DONE;
    error    = state == S_ERROR;
    cpu_hold = state != S_DONE;
    too_big  = 32'(in_data) > 32'(DEPTH);
  end
  // frame parser; count-1 truncated to ADDR_W makes a zero count address the full memory
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      last        <= '0;
      chk         <= '0;
      lo          <= '0;
      mem_address <= '0;
      mem_data    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: if (start) begin
          state <= S_COUNT;
          idx   <= '0;
          chk   <= '0;
        end
        S_COUNT: if (accept) begin
          chk   <= chk ^ in_data;
          last  <= ADDR_W'(in_data - 1'b1);
          state <= too_big ? S_ERROR : S_LO;
        end
        S_LO: if (accept) begin
          lo    <= in_data;
          chk   <= chk ^ in_data;
          state <= S_HI;
        end
        S_HI: if (accept) begin
          chk         <= chk ^ in_data;
          mem_address <= idx;
          mem_data    <= INST_W'({in_data, lo});
          state       <= S_WRITE;
        end
        S_WRITE: begin
          idx   <= (idx == last) ? idx : idx + 1'b1;
          state <= (idx == last) ? S_CHECK : S_LO;
        end
        S_CHECK: if (accept) state <= (in_data == chk) ? S_DONE : S_ERROR;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized frames against a queue-based scoreboard of expected writes and outcomes
module tb_prog_loader;
  localparam int AW = 5;
  localparam int IW = 10;
  localparam int BW = 8;
  logic          clock = 0;
  logic          reset = 0;
  logic          start = 0;
  logic          in_valid = 0;
  logic [BW-1:0] in_data = 0;
  logic          in_ready, mem_wren, cpu_hold, done, error;
  logic [AW-1:0] mem_address;
  logic [IW-1:0] mem_data;
  int total = 0;
  int bad = 0;
  int qa[$];
  int qd[$];
  int qo[$];
  logic [7:0] lo_b[32];
  logic [7:0] hi_b[32];
  logic prev_d = 0;
  logic prev_e = 0;

  prog_loader #(.ADDR_W(AW), .INST_W(IW), .BYTE_W(BW)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_wren(mem_wren), .mem_address(mem_address), .mem_data(mem_data),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  function automatic void check(string name, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endfunction

  always @(negedge clock) begin
    int e;
    if (!reset) begin
      prev_d <= 0;
      prev_e <= 0;
    end else begin
      if (mem_wren) begin
        check("ready_in_write", int'(in_ready), 0);
        if (qa.size() == 0) check("unexpected_write", 1, 0);
        else begin
          check("wr_addr", int'(mem_address), qa.pop_front());
          check("wr_data", int'(mem_data), qd.pop_front());
        end
      end
      if ((done && !prev_d) || (error && !prev_e)) begin
        if (qo.size() == 0) check("unexpected_end", 1, 0);
        else begin
          e = qo.pop_front();
          check("outcome", done ? 1 : 2, e);
          check("cpu_hold_end", int'(cpu_hold), (e == 2) ? 1 : 0);
          check("done_err_excl", int'(done && error), 0);
        end
      end
      prev_d <= done;
      prev_e <= error;
    end
  end

  task automatic start_pulse();
    start = 1;
    @(negedge clock);
    start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic tog, input logic st);
    int t = 0;
    if (tog) begin
      in_valid = 0;
      in_data = 8'($urandom);
      @(negedge clock);
    end
    while (!in_ready && t < 50) begin
      in_valid = 0;
      in_data = 8'($urandom);
      @(negedge clock);
      t++;
    end
    if (t >= 50) check("ready_timeout", 0, 1);
    in_valid = 1;
    in_data = b;
    start = st;
    @(negedge clock);
    in_valid = 0;
    start = 0;
    in_data = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] cnt, input logic tog, input logic [7:0] cx, input logic rs);
    int n;
    int t = 0;
    logic [7:0] c;
    n = (cnt == 0) ? 32 : int'(cnt);
    start_pulse();
    if (n > 32) begin
      qo.push_back(2);
      send_byte(cnt, tog, 0);
      check("count_err_next", int'(error), 1);
    end else begin
      c = cnt;
      qo.push_back(cx == 0 ? 1 : 2);
      for (int i = 0; i < n; i++) begin
        c = c ^ lo_b[i] ^ hi_b[i];
        qa.push_back(i);
        qd.push_back(int'(IW'({hi_b[i], lo_b[i]})));
      end
      send_byte(cnt, tog, 0);
      for (int i = 0; i < n; i++) begin
        send_byte(lo_b[i], tog, rs && $urandom_range(0, 1) == 1);
        send_byte(hi_b[i], tog, rs && $urandom_range(0, 1) == 1);
      end
      send_byte(c ^ cx, tog, rs);
    end
    while (qo.size() != 0 && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("frame_end_seen", qo.size(), 0);
    check("writes_drained", qa.size(), 0);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 32; i++) begin
      lo_b[i] = 8'($urandom);
      hi_b[i] = 8'($urandom);
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_cpu_hold", int'(cpu_hold), 1);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_mem_wren", int'(mem_wren), 0);
    reset = 1;
    @(negedge clock);
    check("idle_in_ready", int'(in_ready), 0);
    lo_b[0] = 8'h55; hi_b[0] = 8'h01; lo_b[1] = 8'hAA; hi_b[1] = 8'h02;
    send_frame(8'h02, 0, 8'h00, 0);
    repeat (3) @(negedge clock);
    check("good_done_held", int'(done), 1);
    check("good_cpu_release", int'(cpu_hold), 0);
    check("good_ready_low", int'(in_ready), 0);
    send_frame(8'h02, 0, 8'hFE, 0);
    check("badchk_error", int'(error), 1);
    check("badchk_done", int'(done), 0);
    check("badchk_hold", int'(cpu_hold), 1);
    send_frame(8'h21, 0, 8'h00, 0);
    for (int i = 0; i < 32; i++) begin
      lo_b[i] = 8'(i);
      hi_b[i] = 8'h00;
    end
    send_frame(8'h00, 0, 8'h00, 0);
    check("full_done", int'(done), 1);
    rand_words();
    send_frame(8'h05, 1, 8'h00, 1);
    check("toggle_done", int'(done), 1);
    for (int k = 0; k < 12; k++) begin
      rand_words();
      send_frame(8'($urandom_range(0, 40)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                 1'($urandom_range(0, 1)));
    end
    rand_words();
    start_pulse();
    send_byte(8'h03, 0, 0);
    send_byte(lo_b[0], 0, 0);
    in_valid = 1;
    in_data = hi_b[0];
    @(posedge clock);
    #1 reset = 0;
    in_valid = 0;
    #1;
    check("mid_rst_hold", int'(cpu_hold), 1);
    check("mid_rst_ready", int'(in_ready), 0);
    check("mid_rst_wren", int'(mem_wren), 0);
    check("mid_rst_addr", int'(mem_address), 0);
    check("mid_rst_data", int'(mem_data), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_error", int'(error), 0);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    send_frame(8'h03, 0, 8'h00, 0);
    check("after_rst_done", int'(done), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, instruction-memory address width (32 words).
REQ-002 SHALL have parameter INST_W, default 10, instruction word width (2..16).
REQ-003 SHALL have parameter BYTE_W, default 8, input byte width.
REQ-004 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-007 SHALL have port in_valid  input  1  byte-stream valid.
REQ-008 SHALL have port in_data  input  BYTE_W  byte-stream data.
REQ-009 SHALL have port in_ready  output  1  loader can accept a byte this cycle.
REQ-010 SHALL have port mem_wren  output  1  instruction-memory write enable.
REQ-011 SHALL have port mem_address  output  ADDR_W  write address.
REQ-012 SHALL have port mem_data  output  INST_W  write data.
REQ-013 SHALL have port cpu_hold  output  1  holds the processor's control unit in reset while high.
REQ-014 SHALL have port done  output  1  load completed with a good checksum.
REQ-015 SHALL have port error  output  1  load aborted (bad count or bad checksum).

Function
REQ-016 Byte accepted only on a rising edge with in_valid=1 and in_ready=1; no other byte has any effect.
REQ-017 Frame format: COUNT byte N, then N words of two bytes each (LO = bits[7:0], HI = bits[INST_W-1:8] in its low bits, upper HI bits ignored), then one CHK byte.
REQ-018 COUNT byte 0 SHALL mean 2^ADDR_W words; COUNT > 2^ADDR_W SHALL go to ERROR on acceptance.
REQ-019 States: IDLE, COUNT, LO, HI, WRITE, CHECK, DONE, ERROR.
REQ-020 in_ready=1 exactly in COUNT, LO, HI and CHECK; 0 in IDLE, WRITE, DONE and ERROR.
REQ-021 IDLE, DONE or ERROR with start=1 -> COUNT next cycle; word index and checksum cleared; done/error cleared; cpu_hold=1.
REQ-022 start SHALL be ignored in COUNT, LO, HI, WRITE and CHECK.
REQ-023 COUNT --accept--> LO (or ERROR per REQ-018); LO --accept--> HI; HI --accept--> WRITE.
REQ-024 WRITE lasts exactly one cycle: mem_wren=1, mem_address=word index, mem_data={HI, LO} truncated to INST_W.
REQ-025 After WRITE: index==N-1 -> CHECK, else index+1 and -> LO; the index never wraps within a frame.
REQ-026 Checksum = XOR of the COUNT byte and all 2N data bytes; CHECK --accept--> DONE if CHK equals the checksum, else ERROR.
REQ-027 mem_wren SHALL be 0 in every state except WRITE; mem_address/mem_data hold their last value otherwise.
REQ-028 DONE: done=1, cpu_hold=0; ERROR: error=1, cpu_hold=1; both held until start or reset.
REQ-029 All outputs SHALL be registered or decoded from state only; no combinational path from in_valid/in_data to any output.

Reset
REQ-030 reset low SHALL force, asynchronously, state=IDLE, cpu_hold=1, in_ready=0, mem_wren=0, mem_address=0, mem_data=0, done=0, error=0, index=0, checksum=0.
REQ-031 Reset mid-frame SHALL abandon the frame; words already written are not restored.

Structure
REQ-032 State encoding and frame constants (COUNT=0 means full) SHALL live in the shared processor package next to the control-unit state codes.
REQ-033 Single flat module; no sub-module needed.

Verification
REQ-034 Frame N=2, words 0x155, 0x2AA (bytes 02 55 01 AA 02 FE) -> writes addr0=0x155, addr1=0x2AA, done=1, cpu_hold=0.
REQ-035 Same frame with CHK=0x00 -> both writes occur, then error=1, done=0, cpu_hold=1.
REQ-036 COUNT=0x21 -> error=1 on the next cycle, no mem_wren pulse.
REQ-037 COUNT=0x00 with 32 words, data=index -> 32 writes to addr 0..31, the last at addr 31, then done with correct CHK.
REQ-038 in_valid toggling 1-0-1 every cycle -> identical write sequence; no byte is lost or duplicated; in_ready=0 in WRITE.
REQ-039 reset asserted after the first HI byte -> immediate IDLE, cpu_hold=1; a following start plus a full frame loads correctly.
